// File: rtl/hack_vga_screen.sv
// VGA scan-out for the 1-bpp Hack screen: programmable timing, fixed-latency word
// fetch into a shift register, and a bordered screen window inside the active area.
module hack_vga_screen #(
  parameter int RGB_WIDTH = 10,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int SCR_W     = 512,
  parameter int SCR_H     = 256,
  parameter int X_OFF     = 64,
  parameter int Y_OFF     = 112,
  parameter int RD_LAT    = 2,
  parameter logic [3*RGB_WIDTH-1:0] BORDER_RGB = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 rd_req,
  output logic [12:0]          rd_addr,
  input  logic [15:0]          rd_data,
  output logic [RGB_WIDTH-1:0] r,
  output logic [RGB_WIDTH-1:0] g,
  output logic [RGB_WIDTH-1:0] b,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank_n,
  output logic                 frame_start,
  output logic                 vblank
);
  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(HT);
  localparam int VW  = $clog2(VT);
  localparam int WPL = SCR_W / 16;
  localparam int CW  = 3 * RGB_WIDTH;
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  if (RD_LAT < 1 || RD_LAT > 14) begin : g_bad_lat
    $error("RD_LAT must be within 1..14");
  end
  if (SCR_W % 16 != 0) begin : g_bad_scr_w
    $error("SCR_W must be a multiple of 16");
  end
  if (X_OFF < RD_LAT + 1) begin : g_bad_x_off
    $error("X_OFF must be at least RD_LAT+1");
  end
  if (X_OFF + SCR_W > H_ACTIVE) begin : g_bad_x_fit
    $error("screen does not fit horizontally");
  end
  if (Y_OFF + SCR_H > V_ACTIVE) begin : g_bad_y_fit
    $error("screen does not fit vertically");
  end

  // started holds the counters at 0,0 for one clock after reset so the first
  // frame_start pulse is visible in counter time.
  logic          started;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  int            hc, vc, hn, vn, sx, sy, fx, fy;
  logic          in_win, active, hs_act, vs_act, fetch, take;
  logic [15:0]   sreg;
  logic [RD_LAT-1:0] rd_pipe;
  logic [CW-1:0] pix;

  assign hc = 32'(h_cnt);
  assign vc = 32'(v_cnt);
  assign hn = 32'(h_nxt);
  assign vn = 32'(v_nxt);

  always_comb begin : next_count
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (started) begin
      if (hc == HT - 1) begin
        h_nxt = '0;
        if (vc == VT - 1) v_nxt = '0;
        else              v_nxt = v_cnt + VW'(1);
      end else begin
        h_nxt = h_cnt + HW'(1);
      end
    end
  end

  assign sx     = hc - X_OFF;
  assign sy     = vc - Y_OFF;
  assign in_win = (sx >= 0) && (sx < SCR_W) && (sy >= 0) && (sy < SCR_H);
  assign active = (hc < H_ACTIVE) && (vc < V_ACTIVE);
  assign hs_act = (hc >= H_ACTIVE + H_FP) && (hc < H_ACTIVE + H_FP + H_SYNC);
  assign vs_act = (vc >= V_ACTIVE + V_FP) && (vc < V_ACTIVE + V_FP + V_SYNC);

  assign frame_start = started && (hc == 0) && (vc == 0);
  assign vblank      = (vc >= V_ACTIVE);

  // Read port: rd_req is a one-cycle strobe with rd_addr valid in the same cycle;
  // there is no back-pressure, and rd_data is valid exactly RD_LAT clocks later.
  // The request is decided from the next counter value so it is registered yet
  // still lands on h_cnt = X_OFF + 16k - RD_LAT - 1.
  assign fx    = hn - X_OFF + RD_LAT + 1;
  assign fy    = vn - Y_OFF;
  assign fetch = (fx >= 0) && (fx < SCR_W) && (fx % 16 == 0) && (fy >= 0) && (fy < SCR_H);

  if (RD_LAT == 1) begin : g_pipe_one
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_pipe <= '0;
      else          rd_pipe <= rd_req;
    end
  end else begin : g_pipe_many
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_pipe <= '0;
      else          rd_pipe <= {rd_pipe[RD_LAT-2:0], rd_req};
    end
  end
  assign take = rd_pipe[RD_LAT-1];

  always_comb begin : colour
    pix = '0;
    if (active) begin
      if (!in_win)      pix = BORDER_RGB;
      else if (sreg[0]) pix = '0;
      else              pix = '1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      rd_req  <= 1'b0;
      rd_addr <= '0;
      sreg    <= '0;
      r       <= '0;
      g       <= '0;
      b       <= '0;
      blank_n <= 1'b0;
      hsync   <= ~HS_ON;
      vsync   <= ~VS_ON;
    end else begin
      started <= 1'b1;
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      rd_req  <= fetch;
      if (fetch) rd_addr <= 13'(fy * WPL + fx / 16);
      if (started) begin
        // A fresh word replaces the last pixel of the previous word, already shown.
        if (take)        sreg <= rd_data;
        else if (in_win) sreg <= sreg >> 1;
        {r, g, b} <= pix;
        blank_n   <= active;
        hsync     <= hs_act ? HS_ON : ~HS_ON;
        vsync     <= vs_act ? VS_ON : ~VS_ON;
      end
    end
  end
endmodule

// File: tb/tb_hack_vga_screen.sv
// Bench for hack_vga_screen: two reduced-size configurations driven side by side,
// fetch and pixel expectations queued up front and popped by per-instance monitors.
`timescale 1ns/1ps
module tb_hack_vga_screen;
  localparam int T_END = 16200;
  localparam int A_HT = 72, A_VT = 18, A_FT = A_HT * A_VT, A_LAT = 4;
  localparam int B_HT = 800, B_VT = 10, B_FT = B_HT * B_VT, B_LAT = 2;
  localparam logic [29:0] B_RED = 30'h3FF00000;
  localparam logic [29:0] B_WHT = 30'h3FFFFFFF;
  localparam logic [11:0] A_GRN = 12'h0F0;
  localparam logic [11:0] A_WHT = 12'hFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        rd_req_a, hsync_a, vsync_a, blank_n_a, frame_start_a, vblank_a;
  logic [12:0] rd_addr_a;
  logic [15:0] rd_data_a = '0;
  logic [3:0]  r_a, g_a, b_a;
  logic        rd_req_b, hsync_b, vsync_b, blank_n_b, frame_start_b, vblank_b;
  logic [12:0] rd_addr_b;
  logic [15:0] rd_data_b = '0;
  logic [9:0]  r_b, g_b, b_b;

  hack_vga_screen #(
    .RGB_WIDTH(4), .H_ACTIVE(64), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2), .HS_POL(1), .VS_POL(0),
    .SCR_W(32), .SCR_H(4), .X_OFF(16), .Y_OFF(4), .RD_LAT(A_LAT), .BORDER_RGB(A_GRN)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .rd_req(rd_req_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .r(r_a), .g(g_a), .b(b_a), .hsync(hsync_a), .vsync(vsync_a),
    .blank_n(blank_n_a), .frame_start(frame_start_a), .vblank(vblank_a)
  );

  hack_vga_screen #(
    .RGB_WIDTH(10), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SCR_H(2), .Y_OFF(2), .RD_LAT(B_LAT), .BORDER_RGB(B_RED)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .rd_req(rd_req_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .r(r_b), .g(g_b), .b(b_b), .hsync(hsync_b), .vsync(vsync_b),
    .blank_n(blank_n_b), .frame_start(frame_start_b), .vblank(vblank_b)
  );

  // t = 0 is the first clock after reset release, i.e. counter position h=0, v=0
  int t;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) t <= -1;
    else          t <= t + 1;

  int n_cmp = 0;
  int n_fail = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp);
    end
  endtask

  logic [34:0] exp_a_q[$];  // {t[19:0], rgb[11:0], blank_n, hsync, vsync}
  logic [52:0] exp_b_q[$];  // {t[19:0], rgb[29:0], blank_n, hsync, vsync}
  logic [32:0] rd_a_q[$];   // {t[19:0], rd_addr}
  logic [32:0] rd_b_q[$];

  task automatic exp_a(input int tt, input logic [11:0] rgb, input logic bl, input logic hs, input logic vs);
    exp_a_q.push_back({20'(tt), rgb, bl, hs, vs});
  endtask
  task automatic exp_b(input int tt, input logic [29:0] rgb, input logic bl, input logic hs, input logic vs);
    exp_b_q.push_back({20'(tt), rgb, bl, hs, vs});
  endtask

  logic [15:0] mem_a [8];
  logic [15:0] mem_b [64];
  logic [35:0] pend_a[$], pend_b[$];  // {due t[19:0], data}

  // Memory responders: correct data only in the one cycle it must be sampled.
  initial forever begin
    logic [35:0] p;
    @(negedge clk);
    if (!reset_n) pend_a.delete();
    else begin
      rd_data_a = 16'($urandom);
      if (pend_a.size() > 0 && pend_a[0][35:16] == 20'(t)) begin
        p = pend_a.pop_front();
        rd_data_a = p[15:0];
      end
      if (rd_req_a) pend_a.push_back({20'(t + A_LAT), mem_a[rd_addr_a[2:0]]});
    end
  end

  initial forever begin
    logic [35:0] p;
    @(negedge clk);
    if (!reset_n) pend_b.delete();
    else begin
      rd_data_b = 16'($urandom);
      if (pend_b.size() > 0 && pend_b[0][35:16] == 20'(t)) begin
        p = pend_b.pop_front();
        rd_data_b = p[15:0];
      end
      if (rd_req_b) pend_b.push_back({20'(t + B_LAT), mem_b[rd_addr_b[5:0]]});
    end
  end

  logic mon_en = 1'b0;
  int   hs_a_high = 0;
  int   blank_b_high = 0, hs_b_low = 0, vs_b_low = 0;
  int   n_hs_fall = 0, hs_fall0 = -1, hs_fall1 = -1, vs_fall = -1;
  logic hs_prev_b = 1'b1, vs_prev_b = 1'b1;

  always @(negedge clk) begin
    logic [34:0] e;
    logic [32:0] q;
    if (mon_en && t >= 0 && t < T_END) begin
      check("frame_start_a", frame_start_a, (t % A_FT) == 0);
      check("vblank_a", vblank_a, ((t / A_HT) % A_VT) >= 12);
      if (exp_a_q.size() > 0 && exp_a_q[0][34:15] == 20'(t)) begin
        e = exp_a_q.pop_front();
        check("pix_a", {r_a, g_a, b_a, blank_n_a, hsync_a, vsync_a}, e[14:0]);
      end
      if (rd_req_a) begin
        if (rd_a_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rd_a_extra t=%0d got strobe addr %0d expected none", t, rd_addr_a);
        end else begin
          q = rd_a_q.pop_front();
          check("rd_a", {20'(t), rd_addr_a}, q);
        end
      end
      if (t >= 1 && t <= A_HT && hsync_a) hs_a_high++;
    end
  end

  always @(negedge clk) begin
    logic [52:0] e;
    logic [32:0] q;
    if (mon_en && t >= 0 && t < T_END) begin
      check("frame_start_b", frame_start_b, (t % B_FT) == 0);
      check("vblank_b", vblank_b, ((t / B_HT) % B_VT) >= 6);
      if (exp_b_q.size() > 0 && exp_b_q[0][52:33] == 20'(t)) begin
        e = exp_b_q.pop_front();
        check("pix_b", {r_b, g_b, b_b, blank_n_b, hsync_b, vsync_b}, e[32:0]);
      end
      if (rd_req_b) begin
        if (rd_b_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rd_b_extra t=%0d got strobe addr %0d expected none", t, rd_addr_b);
        end else begin
          q = rd_b_q.pop_front();
          check("rd_b", {20'(t), rd_addr_b}, q);
        end
      end
      if (t >= 1 && t <= B_HT) begin
        if (blank_n_b) blank_b_high++;
        if (!hsync_b)  hs_b_low++;
      end
      if (t >= 1 && t <= B_FT && !vsync_b) vs_b_low++;
      if (t < B_FT && hs_prev_b && !hsync_b) begin
        if (n_hs_fall == 0)      hs_fall0 = t;
        else if (n_hs_fall == 1) hs_fall1 = t;
        n_hs_fall++;
      end
      if (t < B_FT && vs_prev_b && !vsync_b && vs_fall < 0) vs_fall = t;
      hs_prev_b = hsync_b;
      vs_prev_b = vsync_b;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_hsync_a"}, hsync_a, 1'b0);
    check({tag, "_hsync_b"}, hsync_b, 1'b1);
    check({tag, "_vsync"}, {vsync_a, vsync_b}, 2'b11);
    check({tag, "_rgb_a"}, {r_a, g_a, b_a}, 12'h0);
    check({tag, "_rgb_b"}, {r_b, g_b, b_b}, 30'h0);
    check({tag, "_blank"}, {blank_n_a, blank_n_b}, 2'b00);
    check({tag, "_rd_req"}, {rd_req_a, rd_req_b}, 2'b00);
    check({tag, "_frame_vblank"}, {frame_start_a, frame_start_b, vblank_a, vblank_b}, 4'h0);
  endtask

  initial begin
    int tt;
    for (int i = 0; i < 8; i++) mem_a[i] = 16'h0000;
    mem_a[0] = 16'hA5C3; mem_a[1] = 16'h0F0F; mem_a[2] = 16'h8001; mem_a[3] = 16'hFFFF;
    for (int i = 0; i < 64; i++) mem_b[i] = 16'h0000;
    mem_b[0] = 16'h0001; mem_b[63] = 16'h8000;

    // A fetches at h=11,27 on lines 4..7; B at h=61+16k on lines 2..3.
    for (int f = 0; f < 13; f++)
      for (int v = 4; v < 8; v++)
        for (int k = 0; k < 2; k++) begin
          tt = f * A_FT + v * A_HT + 11 + 16 * k;
          if (tt < T_END) rd_a_q.push_back({20'(tt), 13'((v - 4) * 2 + k)});
        end
    for (int f = 0; f < 2; f++)
      for (int v = 2; v < 4; v++)
        for (int k = 0; k < 32; k++)
          rd_b_q.push_back({20'(f * B_FT + v * B_HT + 61 + 16 * k), 13'((v - 2) * 32 + k)});

    // Output for counter position (h,v) appears at t = v*HT + h + 1.
    exp_a(66, 12'h0, 0, 0, 1);     exp_a(67, 12'h0, 0, 1, 1);
    exp_a(70, 12'h0, 0, 1, 1);     exp_a(71, 12'h0, 0, 0, 1);
    exp_a(304, A_GRN, 1, 0, 1);    exp_a(305, 12'h0, 1, 0, 1);
    exp_a(306, 12'h0, 1, 0, 1);    exp_a(307, A_WHT, 1, 0, 1);
    exp_a(320, 12'h0, 1, 0, 1);    exp_a(321, 12'h0, 1, 0, 1);
    exp_a(325, A_WHT, 1, 0, 1);    exp_a(336, A_WHT, 1, 0, 1);
    exp_a(337, A_GRN, 1, 0, 1);    exp_a(353, 12'h0, 0, 0, 1);
    exp_a(377, 12'h0, 1, 0, 1);    exp_a(378, A_WHT, 1, 0, 1);
    exp_a(392, 12'h0, 1, 0, 1);    exp_a(525, A_WHT, 1, 0, 1);
    exp_a(1008, 12'h0, 0, 0, 1);   exp_a(1009, 12'h0, 0, 0, 0);
    exp_a(1601, 12'h0, 1, 0, 1);

    exp_b(1, B_RED, 1, 1, 1);      exp_b(11, B_RED, 1, 1, 1);
    exp_b(640, B_RED, 1, 1, 1);    exp_b(641, 30'h0, 0, 1, 1);
    exp_b(656, 30'h0, 0, 1, 1);    exp_b(657, 30'h0, 0, 0, 1);
    exp_b(752, 30'h0, 0, 0, 1);    exp_b(753, 30'h0, 0, 1, 1);
    exp_b(1664, B_RED, 1, 1, 1);   exp_b(1665, 30'h0, 1, 1, 1);
    exp_b(1666, B_WHT, 1, 1, 1);   exp_b(2176, B_WHT, 1, 1, 1);
    exp_b(2465, B_WHT, 1, 1, 1);   exp_b(2975, B_WHT, 1, 1, 1);
    exp_b(2976, 30'h0, 1, 1, 1);   exp_b(2977, B_RED, 1, 1, 1);
    exp_b(3101, 30'h0, 0, 0, 1);   exp_b(5600, 30'h0, 0, 1, 1);
    exp_b(5601, 30'h0, 0, 1, 0);   exp_b(7200, 30'h0, 0, 1, 0);
    exp_b(7201, 30'h0, 0, 1, 1);   exp_b(9665, 30'h0, 1, 1, 1);

    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    #1 check_reset("por");
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (T_END + 1) @(negedge clk);
    #1 mon_en = 1'b0;

    check("pix_a_left", exp_a_q.size(), 0);
    check("pix_b_left", exp_b_q.size(), 0);
    check("rd_a_left", rd_a_q.size(), 0);
    check("rd_b_left", rd_b_q.size(), 0);
    check("hs_a_high_per_line", hs_a_high, 4);
    check("blank_b_high_per_line", blank_b_high, 640);
    check("hs_b_low_per_line", hs_b_low, 96);
    check("hs_b_first_fall", hs_fall0, 657);
    check("hs_b_period", hs_fall1 - hs_fall0, 800);
    check("vs_b_low_per_frame", vs_b_low, 1600);
    check("vs_b_first_fall", vs_fall, 5601);

    // Mid-line reset takes effect without a clock edge.
    reset_n = 1'b0;
    #1 check_reset("mid");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("restart_frame_start", {frame_start_a, frame_start_b}, 2'b11);
    check("restart_blank_b_t0", blank_n_b, 1'b0);
    @(negedge clk);
    #1;
    check("restart_frame_start_t1", {frame_start_a, frame_start_b}, 2'b00);
    check("restart_pix_b_t1", {r_b, g_b, b_b, blank_n_b}, {B_RED, 1'b1});
    check("restart_hsync_a_t1", hsync_a, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
